// File: rtl/parity_scan_pkg.sv
// Shared types and constants for the parity-scrub engine.
package parity_scan_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } scan_state_e;

  // Parity mode encoding as latched on an accepted start.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Width of a select field for n items; never narrower than one bit.
  function automatic int unsigned bank_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Bank/address walker: address is the inner index, bank the outer one.
module scan_addr_gen
  import parity_scan_pkg::*;
#(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned BANK_W    = bank_width(NUM_BANKS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [BANK_W-1:0] LastBank = BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_wrap;
  logic              bank_wrap;

  assign addr_wrap = (addr_q == LastAddr);
  assign bank_wrap = (bank_q == LastBank);

  // Next location: load restarts at (0,0); an enabled step advances addr, carrying into bank.
  always_comb begin
    bank_d = bank_q;
    addr_d = addr_q;
    if (load) begin
      bank_d = '0;
      addr_d = '0;
    end else if (en) begin
      if (addr_wrap) begin
        addr_d = '0;
        bank_d = bank_wrap ? '0 : bank_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Location registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end

  assign bank = bank_q;
  assign addr = addr_q;
  assign last = addr_wrap && bank_wrap;

endmodule

// File: rtl/parity_scan_engine.sv
// Parity-scrub engine: sweeps every word of every bank, streams a per-word verdict,
// counts failures (saturating) and remembers where the first failure was.
module parity_scan_engine
  import parity_scan_pkg::*;
#(
  parameter int unsigned  DATA_W    = 8,
  parameter int unsigned  ADDR_W    = 3,
  parameter int unsigned  NUM_BANKS = 2,
  localparam int unsigned BANK_W    = bank_width(NUM_BANKS),
  localparam int unsigned CNT_W     = ADDR_W + BANK_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_odd,
  input  logic              pause,
  output logic              rd_en,
  output logic [BANK_W-1:0] rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_parity,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic              res_ok,
  output logic [BANK_W-1:0] res_bank,
  output logic [ADDR_W-1:0] res_addr,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [BANK_W-1:0] first_err_bank,
  output logic [ADDR_W-1:0] first_err_addr
);

  scan_state_e state_q, state_d;
  logic        mode_q, mode_d;

  // Address generator handshake.
  logic              gen_load;
  logic              gen_en;
  logic [BANK_W-1:0] gen_bank;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;

  logic issue;
  logic clear_errs;
  logic parity_ok;

  // Stage 1: location of the read whose data is on rd_data this cycle.
  logic              s1_valid_q, s1_valid_d;
  logic [BANK_W-1:0] s1_bank_q, s1_bank_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

  // Stage 2: registered verdict.
  logic              res_valid_q, res_valid_d;
  logic              res_ok_q, res_ok_d;
  logic [BANK_W-1:0] res_bank_q, res_bank_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;

  // Error bookkeeping.
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              fev_q, fev_d;
  logic [BANK_W-1:0] feb_q, feb_d;
  logic [ADDR_W-1:0] fea_q, fea_d;

  scan_addr_gen #(
    .ADDR_W   (ADDR_W),
    .NUM_BANKS(NUM_BANKS),
    .BANK_W   (BANK_W)
  ) u_addr_gen (
    .clock(clock),
    .reset(reset),
    .load (gen_load),
    .en   (gen_en),
    .bank (gen_bank),
    .addr (gen_addr),
    .last (gen_last)
  );

  // Controller: start/load in idle, issue reads in scan, wait out the pipeline, pulse done.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    gen_load   = 1'b0;
    gen_en     = 1'b0;
    issue      = 1'b0;
    clear_errs = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StScan;
          gen_load   = 1'b1;
          clear_errs = 1'b1;
          mode_d     = mode_odd ? PAR_ODD : PAR_EVEN;
        end
      end
      StScan: begin
        issue  = !pause;
        gen_en = issue;
        if (issue && gen_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Stage 1 empty means the final verdict is being registered this cycle.
        if (!s1_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign parity_ok = (((^rd_data) ^ rd_parity) == mode_q);

  // Location pipeline and verdict formation.
  always_comb begin
    s1_valid_d  = issue;
    s1_bank_d   = s1_bank_q;
    s1_addr_d   = s1_addr_q;
    res_valid_d = s1_valid_q;
    res_ok_d    = s1_valid_q && parity_ok;
    res_bank_d  = res_bank_q;
    res_addr_d  = res_addr_q;
    if (issue) begin
      s1_bank_d = gen_bank;
      s1_addr_d = gen_addr;
    end
    if (s1_valid_q) begin
      res_bank_d = s1_bank_q;
      res_addr_d = s1_addr_q;
    end
  end

  // Error count and first-failure capture, timed to match the verdict.
  always_comb begin
    err_count_d = err_count_q;
    fev_d       = fev_q;
    feb_d       = feb_q;
    fea_d       = fea_q;
    if (clear_errs) begin
      err_count_d = '0;
      fev_d       = 1'b0;
      feb_d       = '0;
      fea_d       = '0;
    end else if (s1_valid_q && !parity_ok) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + 1'b1;
      end
      if (!fev_q) begin
        fev_d = 1'b1;
        feb_d = s1_bank_q;
        fea_d = s1_addr_q;
      end
    end
  end

  // State, pipeline and bookkeeping registers; reset also drops in-flight reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      mode_q      <= PAR_EVEN;
      s1_valid_q  <= 1'b0;
      s1_bank_q   <= '0;
      s1_addr_q   <= '0;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
      res_bank_q  <= '0;
      res_addr_q  <= '0;
      err_count_q <= '0;
      fev_q       <= 1'b0;
      feb_q       <= '0;
      fea_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_bank_q   <= s1_bank_d;
      s1_addr_q   <= s1_addr_d;
      res_valid_q <= res_valid_d;
      res_ok_q    <= res_ok_d;
      res_bank_q  <= res_bank_d;
      res_addr_q  <= res_addr_d;
      err_count_q <= err_count_d;
      fev_q       <= fev_d;
      feb_q       <= feb_d;
      fea_q       <= fea_d;
    end
  end

  assign rd_en           = issue;
  assign rd_bank         = gen_bank;
  assign rd_addr         = gen_addr;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);
  assign res_valid       = res_valid_q;
  assign res_ok          = res_ok_q;
  assign res_bank        = res_bank_q;
  assign res_addr        = res_addr_q;
  assign err_count       = err_count_q;
  assign first_err_valid = fev_q;
  assign first_err_bank  = feb_q;
  assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_parity_scan_engine.sv
// Bench for parity_scan_engine: a default instance (2x8 words, 8-bit) and a 3x4-word,
// 16-bit instance, each fed by a registered memory model, checked against a
// word-list reference model.
module tb_parity_scan_engine;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, mode_odd, pause, start_a, start_b;

  // Instance A: defaults.
  logic       rd_en_a, rd_par_a, busy_a, done_a, rv_a, rok_a, fev_a;
  logic [0:0] rd_bank_a, rb_a, fb_a;
  logic [2:0] rd_addr_a, ra_a, fa_a;
  logic [7:0] rd_data_a;
  logic [4:0] ec_a;

  // Instance B: three banks of four 16-bit words.
  logic        rd_en_b, rd_par_b, busy_b, done_b, rv_b, rok_b, fev_b;
  logic [1:0]  rd_bank_b, rb_b, fb_b;
  logic [1:0]  rd_addr_b, ra_b, fa_b;
  logic [15:0] rd_data_b;
  logic [4:0]  ec_b;

  parity_scan_engine dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mode_odd(mode_odd), .pause(pause),
    .rd_en(rd_en_a), .rd_bank(rd_bank_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .rd_parity(rd_par_a), .busy(busy_a), .done(done_a), .res_valid(rv_a), .res_ok(rok_a),
    .res_bank(rb_a), .res_addr(ra_a), .err_count(ec_a), .first_err_valid(fev_a),
    .first_err_bank(fb_a), .first_err_addr(fa_a)
  );

  parity_scan_engine #(.DATA_W(16), .ADDR_W(2), .NUM_BANKS(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .mode_odd(mode_odd), .pause(pause),
    .rd_en(rd_en_b), .rd_bank(rd_bank_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_parity(rd_par_b), .busy(busy_b), .done(done_b), .res_valid(rv_b), .res_ok(rok_b),
    .res_bank(rb_b), .res_addr(ra_b), .err_count(ec_b), .first_err_valid(fev_b),
    .first_err_bank(fb_b), .first_err_addr(fa_b)
  );

  // Memory contents: [instance][bank][addr]; instance A uses the low byte.
  logic [15:0] memd [2][3][8];
  logic        memp [2][3][8];

  // Registered read port: data appears the cycle after rd_en.
  always @(posedge clock) begin
    if (rd_en_a) begin
      rd_data_a <= memd[0][rd_bank_a][rd_addr_a][7:0];
      rd_par_a  <= memp[0][rd_bank_a][rd_addr_a];
    end
    if (rd_en_b) begin
      rd_data_b <= memd[1][rd_bank_b][rd_addr_b];
      rd_par_b  <= memp[1][rd_bank_b][rd_addr_b];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int bank;
    int addr;
    bit ok;
  } ev_t;

  ev_t res_a[$], res_b[$], rds_a[$], rds_b[$];
  int  dn_a[$], dn_b[$];

  // Observation log, sampled mid-cycle.
  always @(negedge clock) begin
    if (rv_a) res_a.push_back('{cyc, int'(rb_a), int'(ra_a), rok_a});
    if (rd_en_a) rds_a.push_back('{cyc, int'(rd_bank_a), int'(rd_addr_a), 1'b0});
    if (done_a) dn_a.push_back(cyc);
    if (rv_b) res_b.push_back('{cyc, int'(rb_b), int'(ra_b), rok_b});
    if (rd_en_b) rds_b.push_back('{cyc, int'(rd_bank_b), int'(rd_addr_b), 1'b0});
    if (done_b) dn_b.push_back(cyc);
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: ordered word list with verdicts, timing and error summary.
  ev_t exp_q[$];
  int  exp_err, exp_fb, exp_fa;
  bit  exp_fev;

  task automatic build_exp(input int sel, input bit mode, input int t0, input int r,
                           input int p);
    int nb = sel ? 3 : 2;
    int na = sel ? 4 : 8;
    logic [15:0] data;
    bit ok;
    exp_q.delete();
    exp_err = 0;
    exp_fev = 1'b0;
    exp_fb  = 0;
    exp_fa  = 0;
    for (int i = 0; i < nb * na; i++) begin
      int b = i / na;
      int a = i % na;
      data = sel ? memd[1][b][a] : {8'h00, memd[0][b][a][7:0]};
      ok = ((($countones(data) + int'(memp[sel][b][a])) % 2) == int'(mode));
      exp_q.push_back('{t0 + 3 + i + ((i >= r) ? p : 0), b, a, ok});
      if (!ok) begin
        if (!exp_fev) begin
          exp_fev = 1'b1;
          exp_fb  = b;
          exp_fa  = a;
        end
        if (exp_err < 31) exp_err++;
      end
    end
  endtask

  // One scan, started in the current (idle) cycle. Pause is high for p cycles starting
  // r cycles after start; poke raises start mid-scan and again on the done cycle.
  task automatic run_scan(input int sel, input bit mode, input int r, input int p,
                          input bit poke);
    int    w = sel ? 12 : 16;
    int    t0, tdone, n;
    string tg = sel ? "B" : "A";
    ev_t   got[$], rds[$];
    int    dq[$];
    logic [31:0] o_ec, o_fev, o_fb, o_fa;
    t0 = cyc;
    mode_odd = mode;
    if (sel == 1) begin
      start_b = 1'b1; res_b.delete(); rds_b.delete(); dn_b.delete();
    end else begin
      start_a = 1'b1; res_a.delete(); rds_a.delete(); dn_a.delete();
    end
    build_exp(sel, mode, t0, r, p);
    step();
    start_a  = 1'b0;
    start_b  = 1'b0;
    mode_odd = 1'($urandom);
    check({tg, ".busy_rise"}, sel ? busy_b : busy_a, 1);
    tdone = t0 + w + 3 + p;
    while (cyc <= tdone) begin
      pause = (p > 0) && (cyc >= t0 + 1 + r) && (cyc < t0 + 1 + r + p);
      if (sel == 1) start_b = poke && (cyc == t0 + 5 || cyc == tdone);
      else start_a = poke && (cyc == t0 + 5 || cyc == tdone);
      step();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    pause   = 1'b0;
    check({tg, ".busy_fall"}, sel ? busy_b : busy_a, 0);
    got  = sel ? res_b : res_a;
    rds  = sel ? rds_b : rds_a;
    dq   = sel ? dn_b : dn_a;
    o_ec = sel ? 32'(ec_b) : 32'(ec_a);
    o_fev = sel ? 32'(fev_b) : 32'(fev_a);
    o_fb = sel ? 32'(fb_b) : 32'(fb_a);
    o_fa = sel ? 32'(fa_b) : 32'(fa_a);
    check({tg, ".n_res"}, got.size(), w);
    n = (got.size() < w) ? got.size() : w;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.res%0d.cyc", tg, i), got[i].cyc, exp_q[i].cyc);
      check($sformatf("%s.res%0d.bank", tg, i), got[i].bank, exp_q[i].bank);
      check($sformatf("%s.res%0d.addr", tg, i), got[i].addr, exp_q[i].addr);
      check($sformatf("%s.res%0d.ok", tg, i), 32'(got[i].ok), 32'(exp_q[i].ok));
    end
    check({tg, ".n_rd"}, rds.size(), w);
    n = (rds.size() < w) ? rds.size() : w;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.rd%0d.cyc", tg, i), rds[i].cyc, exp_q[i].cyc - 2);
      check($sformatf("%s.rd%0d.loc", tg, i), {rds[i].bank[15:0], rds[i].addr[15:0]},
            {exp_q[i].bank[15:0], exp_q[i].addr[15:0]});
    end
    check({tg, ".n_done"}, dq.size(), 1);
    if (dq.size() > 0) check({tg, ".done_cyc"}, dq[0], tdone);
    check({tg, ".err_count"}, o_ec, exp_err);
    check({tg, ".first_valid"}, o_fev, 32'(exp_fev));
    check({tg, ".first_bank"}, o_fb, exp_fb);
    check({tg, ".first_addr"}, o_fa, exp_fa);
  endtask

  task automatic randomize_mem(input int sel);
    for (int b = 0; b < 3; b++) begin
      for (int a = 0; a < 8; a++) begin
        memd[sel][b][a] = 16'($urandom);
        memp[sel][b][a] = 1'($urandom);
      end
    end
  endtask

  initial begin
    int t0;
    bit m;
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    pause    = 1'b0;
    mode_odd = 1'b0;
    rd_data_a = '0;
    rd_par_a  = 1'b0;
    rd_data_b = '0;
    rd_par_b  = 1'b0;
    foreach (memd[i, j, k]) begin
      memd[i][j][k] = '0;
      memp[i][j][k] = 1'b0;
    end
    repeat (3) step();
    check("reset.a", {busy_a, rd_en_a, done_a, rv_a, rok_a, ec_a, fev_a, fb_a, fa_a,
                      rd_bank_a, rd_addr_a, rb_a, ra_a}, 0);
    check("reset.b", {busy_b, rd_en_b, done_b, rv_b, rok_b, ec_b, fev_b, fb_b, fa_b,
                      rd_bank_b, rd_addr_b, rb_b, ra_b}, 0);
    reset = 1'b0;

    // Bank 0 holds 8'h1F/1, bank 1 holds 8'h22/0: every word good in even mode.
    for (int a = 0; a < 8; a++) begin
      memd[0][0][a] = 16'h001F;
      memp[0][0][a] = 1'b1;
      memd[0][1][a] = 16'h0022;
      memp[0][1][a] = 1'b0;
    end
    run_scan(0, 1'b0, 0, 0, 1'b0);
    run_scan(0, 1'b1, 0, 0, 1'b0);
    memp[0][1][5] = 1'b1;
    run_scan(0, 1'b0, 0, 0, 1'b0);
    memp[0][1][5] = 1'b0;
    // Three pause cycles right after the fourth read.
    run_scan(0, 1'b0, 4, 3, 1'b0);

    // Reset in the middle of an odd-mode (all-failing) scan.
    t0 = cyc;
    mode_odd = 1'b1;
    start_a = 1'b1;
    dn_a.delete();
    step();
    start_a = 1'b0;
    while (cyc < t0 + 8) step();
    reset = 1'b1;
    step();
    check("reset_mid", {busy_a, rd_en_a, done_a, rv_a, rok_a, ec_a, fev_a, fb_a, fa_a,
                        rd_bank_a, rd_addr_a, rb_a, ra_a}, 0);
    reset = 1'b0;
    repeat (25) step();
    check("reset_mid.no_done", dn_a.size(), 0);
    run_scan(0, 1'b0, 0, 0, 1'b0);

    // Random contents and pause windows; the last one also pokes start.
    for (int k = 0; k < 3; k++) begin
      randomize_mem(0);
      run_scan(0, 1'($urandom), $urandom_range(0, 14), $urandom_range(0, 4), k == 2);
    end

    // Three-bank instance: exactly one bad word per bank, start poked while busy.
    m = 1'($urandom);
    randomize_mem(1);
    for (int b = 0; b < 3; b++) begin
      int bad = $urandom_range(0, 3);
      for (int a = 0; a < 4; a++) begin
        memp[1][b][a] = (^memd[1][b][a]) ^ m ^ (a == bad);
      end
    end
    run_scan(1, m, 0, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      randomize_mem(1);
      run_scan(1, 1'($urandom), $urandom_range(0, 10), $urandom_range(1, 4), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
